// File: rtl/snn_pkg.sv
// Shared definitions for the spike event encoder: default sizes, FSM states
// and the neuron-ID type.
package snn_pkg;

  localparam int NUM_NEURONS = 16;
  localparam int ADDR_W      = $clog2(NUM_NEURONS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [ADDR_W-1:0] neuron_id_t;

endpackage

// File: rtl/lsb_priority_encoder.sv
// Combinational search for the lowest set bit of a vector; index is 0 and
// valid is low when no bit is set.
module lsb_priority_encoder #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);

  // Scanning downward lets the lowest set bit overwrite any higher match.
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = W'(i);
      end
    end
  end

  assign valid_o = |vec_i;

endmodule

// File: rtl/spike_event_encoder.sv
// Converts a spike vector into a stream of neuron-ID events pushed into a FIFO
// in ascending ID order, one per cycle, honouring FIFO backpressure.
module spike_event_encoder #(
  parameter int NUM_NEURONS = snn_pkg::NUM_NEURONS,
  parameter int ADDR_W      = snn_pkg::ADDR_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_NEURONS-1:0] spikes,
  input  logic                   fifo_full,
  output logic                   wen,
  output logic [ADDR_W-1:0]      din,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_W:0]        event_count
);

  import snn_pkg::*;

  state_e                 state_q, state_d;
  logic [NUM_NEURONS-1:0] pendingMask_q, pendingMask_d;
  logic [ADDR_W:0]        eventCount_q, eventCount_d;
  logic [ADDR_W-1:0]      lowestId;
  logic                   maskValid;
  logic                   pushC;
  logic                   doneC;

  lsb_priority_encoder #(
    .N(NUM_NEURONS),
    .W(ADDR_W)
  ) u_lsb (
    .vec_i  (pendingMask_q),
    .idx_o  (lowestId),
    .valid_o(maskValid)
  );

  always_comb begin
    state_d       = state_q;
    pendingMask_d = pendingMask_q;
    eventCount_d  = eventCount_q;
    pushC         = 1'b0;
    doneC         = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          pendingMask_d = spikes;
          eventCount_d  = '0;
          state_d       = (spikes != '0) ? SCAN : DONE;
        end
      end
      SCAN: begin
        if (maskValid && !fifo_full) begin
          pushC                   = 1'b1;
          pendingMask_d[lowestId] = 1'b0;
          eventCount_d            = eventCount_q + (ADDR_W+1)'(1);
          // Leave on the edge that pushes the final bit, so no dead SCAN cycle.
          if (pendingMask_d == '0) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        doneC   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      pendingMask_q <= '0;
      eventCount_q  <= '0;
    end else begin
      state_q       <= state_d;
      pendingMask_q <= pendingMask_d;
      eventCount_q  <= eventCount_d;
    end
  end

  // Outputs are masked while reset is high so an in-flight frame stops at once.
  assign wen         = pushC & ~reset;
  assign done        = doneC & ~reset;
  assign busy        = (state_q != IDLE) & ~reset;
  assign din         = lowestId;
  assign event_count = eventCount_q;

endmodule

// File: tb/tb_spike_event_encoder.sv
// Directed self-checking bench for spike_event_encoder; inputs change and
// outputs are sampled on the falling clock edge.
module tb_spike_event_encoder;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] spikes;
  logic        fifo_full;
  logic        wen;
  logic [3:0]  din;
  logic        busy;
  logic        done;
  logic [4:0]  event_count;

  int checks = 0;
  int errors = 0;

  spike_event_encoder dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .spikes     (spikes),
    .fifo_full  (fifo_full),
    .wen        (wen),
    .din        (din),
    .busy       (busy),
    .done       (done),
    .event_count(event_count)
  );

  always #5 clock = ~clock;

  task automatic stepCycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic applyStimulus(input logic s, input logic [15:0] v, input logic f);
    start     = s;
    spikes    = v;
    fifo_full = f;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    automatic logic [3:0] ids8421 [4] = '{4'd0, 4'd5, 4'd10, 4'd15};

    reset = 1'b1;
    applyStimulus(1'b0, 16'h0000, 1'b0);
    @(negedge clock);
    stepCycle();
    checkOutput("rst_wen", 32'(wen), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    stepCycle();
    checkOutput("rst_count", 32'(event_count), 32'd0);
    checkOutput("rst_din", 32'(din), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);

    // Empty frame: straight to DONE.
    applyStimulus(1'b1, 16'h0000, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("empty_wen", 32'(wen), 32'd0);
    checkOutput("empty_done", 32'(done), 32'd1);
    checkOutput("empty_busy", 32'(busy), 32'd1);
    checkOutput("empty_count", 32'(event_count), 32'd0);
    stepCycle();
    checkOutput("empty_done_end", 32'(done), 32'd0);
    checkOutput("empty_idle_busy", 32'(busy), 32'd0);

    // Sparse frame 16'h8421.
    applyStimulus(1'b1, 16'h8421, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 16'h0000, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("f8421_wen%0d", k), 32'(wen), 32'd1);
      checkOutput($sformatf("f8421_din%0d", k), 32'(din), 32'(ids8421[k]));
      checkOutput($sformatf("f8421_done%0d", k), 32'(done), 32'd0);
      stepCycle();
    end
    checkOutput("f8421_wen_end", 32'(wen), 32'd0);
    checkOutput("f8421_done", 32'(done), 32'd1);
    checkOutput("f8421_count", 32'(event_count), 32'd4);
    stepCycle();
    checkOutput("f8421_done_end", 32'(done), 32'd0);
    checkOutput("f8421_count_hold", 32'(event_count), 32'd4);

    // Full frame: 16 pushes, count reaches 16 without wrapping.
    applyStimulus(1'b1, 16'hFFFF, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 16'h0000, 1'b0);
    for (int k = 0; k < 16; k++) begin
      checkOutput($sformatf("ffff_wen%0d", k), 32'(wen), 32'd1);
      checkOutput($sformatf("ffff_din%0d", k), 32'(din), 32'(k));
      stepCycle();
    end
    checkOutput("ffff_done", 32'(done), 32'd1);
    checkOutput("ffff_wen_end", 32'(wen), 32'd0);
    checkOutput("ffff_count", 32'(event_count), 32'd16);
    stepCycle();

    // Backpressure on 16'h0003 for cycles t+2..t+4.
    applyStimulus(1'b1, 16'h0003, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("bp_wen_t1", 32'(wen), 32'd1);
    checkOutput("bp_din_t1", 32'(din), 32'd0);
    stepCycle();
    for (int k = 2; k <= 4; k++) begin
      applyStimulus(1'b0, 16'h0000, 1'b1);
      #1;
      checkOutput($sformatf("bp_wen_t%0d", k), 32'(wen), 32'd0);
      checkOutput($sformatf("bp_din_t%0d", k), 32'(din), 32'd1);
      checkOutput($sformatf("bp_busy_t%0d", k), 32'(busy), 32'd1);
      checkOutput($sformatf("bp_count_t%0d", k), 32'(event_count), 32'd1);
      stepCycle();
    end
    applyStimulus(1'b0, 16'h0000, 1'b0);
    #1;
    checkOutput("bp_wen_t5", 32'(wen), 32'd1);
    checkOutput("bp_din_t5", 32'(din), 32'd1);
    stepCycle();
    checkOutput("bp_done_t6", 32'(done), 32'd1);
    checkOutput("bp_count", 32'(event_count), 32'd2);

    // Start raised during DONE is ignored; accepted in the following IDLE cycle.
    applyStimulus(1'b1, 16'h00F0, 1'b0);
    stepCycle();
    checkOutput("b2b_idle_busy", 32'(busy), 32'd0);
    checkOutput("b2b_idle_wen", 32'(wen), 32'd0);
    checkOutput("b2b_idle_count", 32'(event_count), 32'd2);
    stepCycle();
    // Second start held high during SCAN must not disturb the frame.
    applyStimulus(1'b1, 16'h0001, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("ign_wen%0d", k), 32'(wen), 32'd1);
      checkOutput($sformatf("ign_din%0d", k), 32'(din), 32'(k + 4));
      stepCycle();
    end
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("ign_done", 32'(done), 32'd1);
    checkOutput("ign_count", 32'(event_count), 32'd4);
    stepCycle();

    // Reset asserted at the second push of 16'h00FF.
    applyStimulus(1'b1, 16'h00FF, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("rs_din0", 32'(din), 32'd0);
    stepCycle();
    checkOutput("rs_din1", 32'(din), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("rs_during_wen", 32'(wen), 32'd0);
    checkOutput("rs_during_busy", 32'(busy), 32'd0);
    stepCycle();
    reset = 1'b0;
    #1;
    checkOutput("rs_after_wen", 32'(wen), 32'd0);
    checkOutput("rs_after_busy", 32'(busy), 32'd0);
    checkOutput("rs_after_done", 32'(done), 32'd0);
    checkOutput("rs_after_count", 32'(event_count), 32'd0);
    checkOutput("rs_after_din", 32'(din), 32'd0);
    stepCycle();
    checkOutput("rs_idle_wen", 32'(wen), 32'd0);
    applyStimulus(1'b1, 16'h0002, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("post_wen", 32'(wen), 32'd1);
    checkOutput("post_din", 32'(din), 32'd1);
    checkOutput("post_count0", 32'(event_count), 32'd0);
    stepCycle();
    checkOutput("post_done", 32'(done), 32'd1);
    checkOutput("post_wen_end", 32'(wen), 32'd0);
    checkOutput("post_count", 32'(event_count), 32'd1);
    stepCycle();
    checkOutput("post_idle_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spike_event_encoder.md
SPIKE_EVENT_ENCODER -- requirements
Module: spike_event_encoder

Interface
REQ-001 Parameter: NUM_NEURONS, 16, width of spike vector; number of encodable neuron IDs.
REQ-002 Parameter: ADDR_W, 4, event ID width, equal to clog2(NUM_NEURONS) and to the event FIFO data width.
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  request to encode `spikes`; sampled only in IDLE.
REQ-006 spikes  in  NUM_NEURONS  spike vector for one timestep; bit i set means neuron i fired.
REQ-007 fifo_full  in  1  backpressure from the event FIFO; no push while high.
REQ-008 wen  out  1  FIFO write enable; one event per cycle when high.
REQ-009 din  out  ADDR_W  FIFO write data: neuron ID of the event being pushed.
REQ-010 busy  out  1  high in SCAN and DONE states.
REQ-011 done  out  1  single-cycle pulse when all events of the frame are pushed.
REQ-012 event_count  out  ADDR_W+1  number of events pushed for the current or last frame.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SCAN and DONE.
REQ-014 In IDLE with start=1, the block SHALL capture spikes into an internal pending mask and clear event_count.
- On the same edge it SHALL go to SCAN if spikes!=0, else to DONE.
REQ-015 start in SCAN or DONE SHALL be ignored, with no effect on the mask, event_count or state.
REQ-016 In SCAN, wen SHALL equal (pending mask!=0) AND NOT fifo_full, decoded combinationally from registered state.
REQ-017 din SHALL be the index of the lowest set bit of the pending mask; din SHALL be 0 when the mask is 0.
REQ-018 On each cycle with wen=1, the block SHALL clear that bit in the mask and increment event_count by 1.
REQ-019 Events SHALL be pushed in strictly ascending neuron ID order, each set bit exactly once.
- No event SHALL be lost or duplicated under any fifo_full pattern.
REQ-020 While fifo_full=1, mask, din, event_count and state SHALL hold.
REQ-021 When the last remaining bit is pushed, the FSM SHALL go SCAN->DONE on the same edge, with no idle SCAN cycle.
REQ-022 In DONE, done SHALL be 1 for exactly one cycle; the FSM SHALL then return to IDLE unconditionally.
REQ-023 Latency: with start accepted at edge t, k set bits and no backpressure:
- wen is high on cycles t+1 .. t+k;
- done is high on cycle t+k+1 (k=0: cycle t+1).
REQ-024 event_count SHALL saturate naturally at NUM_NEURONS, with no wrap.
- It SHALL hold its value after done until the next accepted start.
REQ-025 busy SHALL be 0 in IDLE.
REQ-026 A new start SHALL be accepted on the cycle after done at the earliest, i.e. back-to-back frames with one IDLE cycle between them.

Reset
REQ-027 reset=1 at any clock edge SHALL force:
- state to IDLE;
- pending mask, event_count and din to 0.
REQ-028 During and on the cycle after reset, wen, busy and done SHALL be 0, including reset asserted mid-SCAN; remaining events are discarded.
REQ-029 reset SHALL take priority over start and fifo_full.

Structure
REQ-030 The package snn_pkg SHALL hold:
- NUM_NEURONS and ADDR_W defaults;
- the state enum typedef (IDLE, SCAN, DONE);
- the neuron-ID typedef logic [ADDR_W-1:0].
REQ-031 The lowest-set-bit search SHALL be one combinational sub-module, lsb_priority_encoder.
- Input: NUM_NEURONS-bit vector.
- Outputs: ADDR_W-bit index and a valid bit.
REQ-032 All other logic SHALL stay in spike_event_encoder, with no further hierarchy.

Verification
REQ-033 spikes=16'h0000, start pulse -> no wen; done on the next cycle; event_count=0.
REQ-034 spikes=16'h8421, fifo_full=0 -> wen for 4 consecutive cycles with din 0,5,10,15; done on the following cycle; event_count=4.
REQ-035 spikes=16'hFFFF -> 16 consecutive pushes with din 0..15; done on cycle t+17; event_count=16 (5'b10000).
REQ-036 spikes=16'h0003, fifo_full=1 for cycles t+2..t+4 -> din=0 at t+1, wen=0 at t+2..t+4, din=1 at t+5, done at t+6; event_count=2.
REQ-037 Start pulses during SCAN (spikes=16'h00F0, second start with 16'h0001) -> only IDs 4,5,6,7 are pushed.
REQ-038 Reset at the second push of 16'h00FF -> wen=0 from the next cycle; busy=0; event_count=0; a following start with 16'h0002 pushes only ID 1.
